// File: rtl/rv_pkg.sv
// Shared core package: ALU branch-op codes and branch-predictor counter types.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // ALU branch-op codes used by the EX-stage branch resolver
  localparam logic [3:0] ALU_BEQ  = 4'b1011;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BLT  = 4'b1101;
  localparam logic [3:0] ALU_BGE  = 4'b1110;
  localparam logic [3:0] ALU_BLTU = 4'b1111;

  // 2-bit saturating direction counter; MSB is the taken prediction
  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = 2'b01;
  localparam bp_ctr_t BP_CTR_ALLOC = 2'b10;
  localparam bp_ctr_t BP_CTR_MAX   = 2'b11;
  localparam bp_ctr_t BP_CTR_MIN   = 2'b00;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter, next-state only.
// Ports:
//   ctr        current counter value
//   inc        1 = count toward taken, 0 = count toward not-taken
//   ctr_next_c saturated next value (combinational)
module bp_sat_ctr
  import rv_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    inc,
  output bp_ctr_t ctr_next_c
);

  always_comb begin
    ctr_next_c = ctr;
    if (inc) begin
      if (ctr != BP_CTR_MAX) ctr_next_c = ctr + 2'd1;
    end else begin
      if (ctr != BP_CTR_MIN) ctr_next_c = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, trains and
// detects mispredicts in EX.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_pc / pred_taken, pred_target    fetch-side lookup (combinational)
//   ex_*                               resolved instruction from EX
//   mispredict, redirect_pc            fetch redirect (combinational)
//   br_count, mp_count                 resolved-branch / mispredict counters
module branch_predictor
  import rv_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  bp_ctr_t             ctr_q    [ENTRIES];

  logic [31:0] br_count_q;
  logic [31:0] mp_count_q;

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic                upd;
  bp_ctr_t             ctr_next;
  logic                unused_pc_lsbs;

  // PC bits [1:0] are always zero for aligned instructions
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Predict from pre-update table state
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
  end

  // Resolve: direction or target disagreement on a branch, or a non-branch
  // that fetch steered away from the fall-through path
  always_comb begin
    upd        = ex_valid && ex_is_branch;
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict = (upd && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target))))
               || (ex_valid && !ex_is_branch && ex_pred_taken);
    redirect_pc = (upd && ex_taken) ? ex_target : ex_pc + 32'd4;
  end

  bp_sat_ctr u_sat_ctr (
    .ctr        (ctr_q[ex_idx]),
    .inc        (ex_taken),
    .ctr_next_c (ctr_next)
  );

  // Table training: update on hit, allocate only on a taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BP_CTR_RESET;
      end
    end else if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= BP_CTR_ALLOC;
      end
    end
  end

  // Event counters, wrapping mod 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_q + 32'(upd);
      mp_count_q <= mp_count_q + 32'(mispredict);
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule
